// File: rtl/tc0260dar_palette.sv
// tc0260dar_palette: palette RAM and colour DAC stage behind the tilemap chip.
// The CPU side uses a chip-select/DTACK handshake clocked by ce_13m.
// The video side looks up each SC index and returns 8-bit RGB two ce_pixel
// later, with the blanking strobes delayed to line up with the colour.
module tc0260dar_palette #(
  parameter int ADDR_W  = 12,
  parameter int PAL_FMT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_13m,
  input  logic              ce_pixel,
  input  logic [ADDR_W:1]   VA,
  input  logic [15:0]       Din,
  output logic [15:0]       Dout,
  input  logic              LDSn,
  input  logic              UDSn,
  input  logic              PCSn,
  input  logic              RW,
  output logic              DACKn,
  input  logic [14:0]       SC,
  input  logic              HBLIn,
  input  logic              VBLIn,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              HBLOn,
  output logic              VBLOn
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCESS, ACK, DONE} state_t;

  state_t            state, state_nxt;
  logic              prev_cs;
  logic              dtack_n;
  logic              cs_take;
  logic              we_hi, we_lo, dout_ld;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_din;
  logic              lat_lds_n, lat_uds_n, lat_rw;
  logic [15:0]       ram [DEPTH];
  logic [15:0]       cpu_q;
  logic [15:0]       vid_q;
  logic [1:0]        blank1;

  // Expand a stored palette word to 8 bits per gun by replicating the MSBs.
  function automatic logic [23:0] expand(input logic [15:0] d);
    if (PAL_FMT == 0)
      expand = {d[14:10], d[14:12], d[9:5], d[9:7], d[4:0], d[4:2]};
    else
      expand = {d[15:12], d[15:12], d[11:8], d[11:8], d[7:4], d[7:4]};
  endfunction

  // SC bits above the RAM index are deliberately ignored, so the index wraps.
  if (ADDR_W < 15) begin : g_wrap
    logic sc_hi_unused;
    assign sc_hi_unused = ^SC[14:ADDR_W];
  end

  // The CPU sees DTACK asserted whenever the chip is not selected.
  assign DACKn = PCSn ? 1'b0 : dtack_n;

  // CPU handshake state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else if (ce_13m)
      state <= state_nxt;
  end

  // Next state and RAM strobes; a deselect aborts any access in flight.
  always_comb begin
    state_nxt = state;
    cs_take   = 1'b0;
    we_hi     = 1'b0;
    we_lo     = 1'b0;
    dout_ld   = 1'b0;
    if (PCSn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (prev_cs) begin
            cs_take   = 1'b1;
            state_nxt = ACCESS;
          end
        end
        ACCESS: begin
          we_hi     = !lat_rw && !lat_uds_n;
          we_lo     = !lat_rw && !lat_lds_n;
          state_nxt = ACK;
        end
        ACK: begin
          dout_ld   = lat_rw;
          state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // CS edge tracking, DTACK and read data towards the CPU.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_cs <= 1'b1;
      dtack_n <= 1'b1;
      Dout    <= 16'h0000;
    end else if (ce_13m) begin
      prev_cs <= PCSn;
      if (PCSn)
        dtack_n <= 1'b1;
      else if (state == ACK)
        dtack_n <= 1'b0;
      if (dout_ld)
        Dout <= cpu_q;
    end
  end

  // Capture the bus cycle on the falling edge of chip select.
  always_ff @(posedge clk) begin
    if (ce_13m && cs_take) begin
      lat_addr  <= VA;
      lat_din   <= Din;
      lat_lds_n <= LDSn;
      lat_uds_n <= UDSn;
      lat_rw    <= RW;
    end
  end

  // CPU port of the palette RAM: byte-lane writes and a registered read.
  always_ff @(posedge clk) begin
    if (ce_13m) begin
      if (we_hi)
        ram[lat_addr][15:8] <= lat_din[15:8];
      if (we_lo)
        ram[lat_addr][7:0] <= lat_din[7:0];
      cpu_q <= ram[lat_addr];
    end
  end

  // Video stage 1: RAM lookup; a same-cycle CPU write is not yet visible.
  always_ff @(posedge clk) begin
    if (ce_pixel)
      vid_q <= ram[SC[ADDR_W-1:0]];
  end

  // Video stages 1 and 2: blank delay and colour decode, black while blanked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank1 <= 2'b00;
      HBLOn  <= 1'b0;
      VBLOn  <= 1'b0;
      R      <= 8'h00;
      G      <= 8'h00;
      B      <= 8'h00;
    end else if (ce_pixel) begin
      blank1         <= {HBLIn, VBLIn};
      {HBLOn, VBLOn} <= blank1;
      if (&blank1)
        {R, G, B} <= expand(vid_q);
      else
        {R, G, B} <= 24'h000000;
    end
  end

endmodule

// File: tb/tb_tc0260dar_palette.sv
// tb_tc0260dar_palette: directed plus randomized bench for the palette/DAC.
// Two instances (RGB555 and RGB444) share all inputs; a behavioural model
// keeps a copy of palette memory and a queue of sampled pixels.
module tb_tc0260dar_palette;

  logic        clk;
  logic        reset_n;
  logic        ce_13m, ce_pixel;
  logic [12:1] VA;
  logic [15:0] Din;
  logic [15:0] Dout0, Dout1;
  logic        LDSn, UDSn, PCSn, RW;
  logic        DACKn0, DACKn1;
  logic [14:0] SC;
  logic        HBLIn, VBLIn;
  logic [7:0]  R0, G0, B0, R1, G1, B1;
  logic        HBLOn0, VBLOn0, HBLOn1, VBLOn1;

  tc0260dar_palette #(.ADDR_W(12), .PAL_FMT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(Dout0), .LDSn(LDSn), .UDSn(UDSn), .PCSn(PCSn),
    .RW(RW), .DACKn(DACKn0), .SC(SC), .HBLIn(HBLIn), .VBLIn(VBLIn),
    .R(R0), .G(G0), .B(B0), .HBLOn(HBLOn0), .VBLOn(VBLOn0));

  tc0260dar_palette #(.ADDR_W(12), .PAL_FMT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(Dout1), .LDSn(LDSn), .UDSn(UDSn), .PCSn(PCSn),
    .RW(RW), .DACKn(DACKn1), .SC(SC), .HBLIn(HBLIn), .VBLIn(VBLIn),
    .R(R1), .G(G1), .B(B1), .HBLOn(HBLOn1), .VBLOn(VBLOn1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  typedef struct packed {
    logic        known;
    logic [23:0] c0;
    logic [23:0] c1;
    logic [1:0]  bl;
  } pix_t;

  int          ncmp = 0;
  int          nfail = 0;
  logic [15:0] mram [4096];
  bit          mknown [4096];
  pix_t        pq [$];
  pix_t        ex;
  logic [11:0] wa;
  logic [15:0] wd;
  bit          wuds_n, wlds_n;
  logic [15:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Colour expansion from the palette word with plain arithmetic.
  function automatic logic [23:0] mcol(input logic [15:0] d, input int fmt);
    int r, g, b;
    if (fmt == 0) begin
      r = (d >> 10) % 32; g = (d >> 5) % 32; b = d % 32;
      r = r * 8 + r / 4;  g = g * 8 + g / 4; b = b * 8 + b / 4;
    end else begin
      r = ((d >> 12) % 16) * 17; g = ((d >> 8) % 16) * 17; b = ((d >> 4) % 16) * 17;
    end
    mcol = {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic pix_t sample();
    pix_t s;
    int   idx;
    idx  = int'(SC) % 4096;
    s.bl = {HBLIn, VBLIn};
    if (!HBLIn || !VBLIn) begin
      s.known = 1'b1; s.c0 = '0; s.c1 = '0;
    end else begin
      s.known = mknown[idx];
      s.c0 = mcol(mram[idx], 0);
      s.c1 = mcol(mram[idx], 1);
    end
    return s;
  endfunction

  task automatic apply_write();
    if (!wuds_n) mram[wa][15:8] = wd[15:8];
    if (!wlds_n) mram[wa][7:0]  = wd[7:0];
    mknown[wa] = mknown[wa] | (!wuds_n && !wlds_n);
  endtask

  task automatic model_reset();
    pq.delete();
    pq.push_back('0);
    ex = '0;
  endtask

  // One clock; the model samples pixels before any CPU write lands (read-first).
  task automatic tick(input bit c13, input bit cp, input bit commit);
    @(negedge clk);
    ce_13m = c13; ce_pixel = cp;
    @(posedge clk);
    #1;
    ce_13m = 1'b0; ce_pixel = 1'b0;
    if (reset_n) begin
      if (cp) begin
        pq.push_back(sample());
        ex = pq.pop_front();
      end
      if (commit) apply_write();
    end
    check("blank_out0", 32'({HBLOn0, VBLOn0}), 32'(ex.bl));
    check("blank_out1", 32'({HBLOn1, VBLOn1}), 32'(ex.bl));
    if (ex.known) begin
      check("rgb_fmt0", 32'({R0, G0, B0}), 32'(ex.c0));
      check("rgb_fmt1", 32'({R1, G1, B1}), 32'(ex.c1));
    end
  endtask

  // One complete CPU bus cycle. cpmode: 0 no pixels, 1 random pixels,
  // 2 a pixel only on the clock where the write lands.
  task automatic cpu(input logic [11:0] a, input logic [15:0] d, input bit uds_n,
                     input bit lds_n, input bit rw, input int cpmode,
                     output logic [15:0] rdata);
    bit cp;
    wa = a; wd = d; wuds_n = uds_n; wlds_n = lds_n;
    VA = a; Din = d; UDSn = uds_n; LDSn = lds_n; RW = rw; PCSn = 1'b0;
    #1;
    check("dack_selected", 32'(DACKn0), 32'(1));
    for (int n = 1; n <= 3; n++) begin
      repeat ($urandom_range(0, 1)) begin
        cp = (cpmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick(1'b0, cp, 1'b0);
        check("dack_hold", 32'(DACKn0), 32'(n > 1 ? 1 : 1));
      end
      cp = (cpmode == 1) ? 1'($urandom_range(0, 1)) : (cpmode == 2 && n == 2);
      tick(1'b1, cp, (n == 2) && !rw);
      check("dack_timing0", 32'(DACKn0), 32'(n < 3));
      check("dack_timing1", 32'(DACKn1), 32'(n < 3));
    end
    if (rw && mknown[a]) begin
      check("dout0", 32'(Dout0), 32'(mram[a]));
      check("dout1", 32'(Dout1), 32'(mram[a]));
    end
    rdata = Dout0;
    PCSn = 1'b1;
    #1;
    check("dack_deselect", 32'(DACKn0), 32'(0));
    tick(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; ce_13m = 1'b0; ce_pixel = 1'b0;
    VA = '0; Din = '0; LDSn = 1'b1; UDSn = 1'b1; PCSn = 1'b1; RW = 1'b1;
    SC = '0; HBLIn = 1'b1; VBLIn = 1'b1;
    for (int i = 0; i < 4096; i++) begin mknown[i] = 1'b0; mram[i] = '0; end
    model_reset();

    // Reset state
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    check("rst_rgb", 32'({R0, G0, B0}), 32'(0));
    check("rst_dack", 32'(DACKn0), 32'(0));
    check("rst_dout", 32'(Dout0), 32'(0));
    reset_n = 1'b1;
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    // Asynchronous reset mid-frame
    reset_n = 1'b0;
    #1;
    check("async_rst_out", 32'({R0, G0, B0, HBLOn0, VBLOn0}), 32'(0));
    check("async_rst_dout", 32'(Dout0), 32'(0));
    check("async_rst_dack", 32'(DACKn0), 32'(0));
    model_reset();
    repeat (2) tick(1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    check("no_x_out", 32'($isunknown({R0, G0, B0, HBLOn0, VBLOn0, DACKn0, Dout0})), 32'(0));

    // Word write then pipelined read
    cpu(12'h010, 16'h7FFF, 1'b0, 1'b0, 1'b0, 0, rd);
    SC = 15'h0010;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("white_rgb", 32'({R0, G0, B0}), 32'h00FFFFFF);

    // Byte writes
    cpu(12'h020, 16'h0000, 1'b0, 1'b0, 1'b0, 0, rd);
    cpu(12'h020, 16'h7C00, 1'b0, 1'b1, 1'b0, 0, rd);
    cpu(12'h020, 16'h0000, 1'b0, 1'b0, 1'b1, 0, rd);
    check("upper_byte_read", 32'(rd), 32'h7C00);
    SC = 15'h0020;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("upper_byte_rgb", 32'({R0, G0, B0}), 32'h00FF0000);
    cpu(12'h020, 16'h001F, 1'b1, 1'b0, 1'b0, 0, rd);
    cpu(12'h020, 16'h0000, 1'b0, 1'b0, 1'b1, 0, rd);
    check("lower_byte_read", 32'(rd), 32'h7C1F);

    // Blanking alignment
    SC = 15'h0010;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    HBLIn = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    HBLIn = 1'b1;
    check("hbl_pre", 32'({R0, G0, B0, HBLOn0}), 32'h01FFFFFF);
    tick(1'b0, 1'b1, 1'b0);
    check("hbl_blank", 32'({R0, G0, B0, HBLOn0}), 32'h0);
    tick(1'b0, 1'b1, 1'b0);
    check("hbl_post", 32'({R0, G0, B0, HBLOn0}), 32'h01FFFFFF);

    // Same-clock CPU write and video read of entry 5
    cpu(12'h005, 16'h03E0, 1'b0, 1'b0, 1'b0, 0, rd);
    SC = 15'h0005;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    cpu(12'h005, 16'h001F, 1'b0, 1'b0, 1'b0, 2, rd);
    tick(1'b0, 1'b1, 1'b0);
    check("collide_old", 32'({R0, G0, B0}), 32'h0000FF00);
    tick(1'b0, 1'b1, 1'b0);
    check("collide_new", 32'({R0, G0, B0}), 32'h000000FF);
    SC = 15'h1005;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("index_wrap", 32'({R0, G0, B0}), 32'h000000FF);

    // Chip select withdrawn mid-access, then a normal cycle
    VA = 12'hFFF; Din = 16'h1234; UDSn = 1'b0; LDSn = 1'b0; RW = 1'b0; PCSn = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    PCSn = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    check("abort_dack", 32'(DACKn0), 32'(0));
    mknown[12'hFFF] = 1'b0;
    cpu(12'h030, 16'hF0A0, 1'b0, 1'b0, 1'b0, 0, rd);
    SC = 15'h0030;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("fmt1_rgb", 32'({R1, G1, B1}), 32'h00FF00AA);

    // Randomized traffic on a small set of entries
    for (int k = 0; k < 8; k++)
      cpu(12'h100 + 12'(k), 16'($urandom), 1'b0, 1'b0, 1'b0, 1, rd);
    for (int it = 0; it < 40; it++) begin
      logic [11:0] a;
      a = 12'h100 + 12'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: cpu(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1, rd);
        1: cpu(a, 16'h0000, 1'b0, 1'b0, 1'b1, 1, rd);
        default: begin
          for (int j = 0; j < 6; j++) begin
            SC = {3'($urandom), 12'h100 + 12'($urandom_range(0, 7))};
            HBLIn = ($urandom_range(0, 3) != 0);
            VBLIn = ($urandom_range(0, 3) != 0);
            tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
          end
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
